// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with start-bit confirmation and stop-bit framing check.
// Oversampling and sample-point defaults live in the defs package below.
package defs;
    localparam int unsigned SAMPLE_CONST = 16;
    localparam int unsigned MID_POINT    = SAMPLE_CONST / 2 - 1;
    localparam int unsigned DATA_BITS    = 8;
endpackage

module uart_rx #(
    parameter int unsigned SAMPLE_CONST = defs::SAMPLE_CONST,
    parameter int unsigned MID_POINT    = defs::MID_POINT,
    parameter int unsigned DATA_BITS    = defs::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(SAMPLE_CONST - 1);
    localparam int unsigned BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID  = TW'(MID_POINT);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CONST - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_rx_s;
    logic [TW-1:0]         r_tick_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;

    // Synchronizer resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (baud_tick && !r_rx_s) begin
                        r_state <= S_START;
                        busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        if (r_tick_cnt == TICK_MID) begin
                            if (!r_rx_s) begin
                                r_tick_cnt <= '0;
                                r_state    <= S_DATA;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            // Right shift: the first bit received ends up in the LSB.
                            r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tick_cnt <= '0;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BW'(1);
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            if (r_rx_s) begin
                                data_out   <= r_shift;
                                data_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            r_tick_cnt <= '0;
                            r_state    <= S_IDLE;
                            busy       <= 1'b0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a frame-level reference model of the UART receiver.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         got_ferr = 0;
    int         exp_ferr = 0;
    logic [7:0] exp_last = 8'h00;
    bit         busy_seen = 1'b0;

    uart_rx #(
        .SAMPLE_CONST(16),
        .MID_POINT   (7),
        .DATA_BITS   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .rx        (rx),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One-cycle tick every 4 clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (data_valid) got_q.push_back(data_out);
        if (frame_err)  got_ferr++;
        if (busy)       busy_seen = 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i == 9) v = stop_bit;
            else             v = b[i-1];
            @(negedge clk);
            rx = v;
            wait_ticks(16);
        end
        if (stop_bit) begin
            exp_q.push_back(b);
            exp_last = b;
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic compare(input string tag);
        logic [31:0] obs;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got_q.size()) ? 32'(got_q[i]) : 'x;
            check({tag, "_byte"}, obs, 32'(exp_q[i]));
        end
        check({tag, "_ferr"}, 32'(got_ferr), 32'(exp_ferr));
        check({tag, "_data_out"}, 32'(data_out), 32'(exp_last));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        got_q.delete();
        exp_q.delete();
        got_ferr = 0;
        exp_ferr = 0;
    endtask

    initial begin
        logic [7:0] b;
        logic       sb;

        // Reset with a toggling line
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = ~rx;
        end
        #1;
        check("rst_data_out", 32'(data_out), 32'(0));
        check("rst_valid", 32'(data_valid), 32'(0));
        check("rst_ferr", 32'(frame_err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rel_data_out", 32'(data_out), 32'(0));
        check("rel_valid", 32'(data_valid), 32'(0));
        check("rel_ferr", 32'(frame_err), 32'(0));
        check("rel_busy", 32'(busy), 32'(0));
        got_q.delete();
        got_ferr = 0;

        // Single byte
        idle(4);
        send_frame(8'hA5, 1'b1);
        idle(4);
        compare("single");

        // False start
        busy_seen = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(3);
        idle(20);
        check("false_busy_seen", 32'(busy_seen), 32'(1));
        compare("false_start");

        // Framing error after a good byte
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b0);
        idle(20);
        compare("frame_err");

        // Back-to-back
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(4);
        compare("b2b");

        // Break: one frame time low gives a single framing error
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(160);
        exp_ferr++;
        idle(20);
        compare("break");

        // Reset during bit 4 of 0x81
        b = 8'h81;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx = (i == 0) ? 1'b0 : b[i-1];
            wait_ticks(16);
        end
        @(negedge clk);
        rx = b[4];
        wait_ticks(8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_data_out", 32'(data_out), 32'(0));
        exp_last = 8'h00;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle(20);
        check("midrst_no_pulse", 32'(got_q.size() + got_ferr), 32'(0));
        send_frame(8'h81, 1'b1);
        idle(4);
        compare("midrst");

        // Randomized frames, occasional bad stop bit
        for (int n = 0; n < 20; n++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            send_frame(b, sb);
            if (sb) idle(int'($urandom_range(0, 3)));
            else    idle(20);
        end
        idle(4);
        compare("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

16x-oversampling UART receiver: converts the asynchronous serial line into parallel bytes with framing checks. Sits directly downstream of the baud generator and consumes its 16x baud tick. Delivers each received byte to the host side as a one-cycle valid pulse. Oversampling and sample-point constants come from the `defs` package.

## Interface
- `SAMPLE_CONST`, default 16: ticks per bit period.
- `MID_POINT`, default 7 (`SAMPLE_CONST/2 - 1`): tick index at which the start bit is confirmed.
- `DATA_BITS`, default 8: payload bits per frame, sent LSB first.

Ports:
- `clk` in, 1: single system clock.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `baud_tick` in, 1: one-`clk` pulse at 16x the selected baud rate, from the baud generator.
- `rx` in, 1: raw asynchronous serial line, idle high.
- `data_out` out, `DATA_BITS`: last good byte received.
- `data_valid` out, 1: one-cycle pulse; `data_out` is new this cycle.
- `frame_err` out, 1: one-cycle pulse when the stop bit is sampled low.
- `busy` out, 1: high in any state other than IDLE.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer, reset to 1, producing `rx_s`. All decisions use `rx_s`.
- **Counters.**
  - `tick_cnt` is `$clog2(SAMPLE_CONST-1)` bits wide (4 bits by default). It advances only on cycles where `baud_tick`=1 and wraps 15→0.
  - `bit_cnt` is `$clog2(DATA_BITS)` bits wide.
- **IDLE**
  - `tick_cnt`=0, `bit_cnt`=0.
  - If `rx_s`=0 on a `baud_tick`, go to START.
- **START**
  - On each tick: if `tick_cnt`==`MID_POINT`, sample `rx_s`.
  - Sample 0: clear `tick_cnt`, go to DATA.
  - Sample 1 (glitch or false start): go to IDLE, no output pulses.
  - Otherwise increment `tick_cnt`.
- **DATA**
  - On each tick: if `tick_cnt`==`SAMPLE_CONST-1`, shift `rx_s` into the MSB of the shift register (right shift, so the byte lands LSB first) and clear `tick_cnt`.
  - If `bit_cnt`==`DATA_BITS-1`, clear `bit_cnt` and go to STOP; otherwise increment `bit_cnt`.
  - Otherwise increment `tick_cnt`.
- **STOP**
  - On the tick where `tick_cnt`==`SAMPLE_CONST-1`, sample `rx_s`.
  - Sample 1: load `data_out` from the shift register and pulse `data_valid`.
  - Sample 0: pulse `frame_err` and leave `data_out` unchanged.
  - Either way, go to IDLE.
- **Break condition.** A line held low re-enters START and frames a 0x00 byte with `frame_err`. This repeats for as long as the line stays low.
- **No handshake.** The host must capture `data_out` on `data_valid`; no overrun indication exists.
- **Ignored input.** `baud_tick` high for more than one cycle counts as multiple ticks; the baud generator guarantees single-cycle pulses.

## Timing
- **Reset values:**
  - `data_out`=0, `data_valid`=0, `frame_err`=0, `busy`=0.
  - State=IDLE, counters=0, synchronizer flops=1.
- **Reset mid-frame.** Asserting `rst_n` low aborts immediately: no pulse is emitted and the output reset values apply asynchronously.
- **Synchronizer latency** is 2 `clk` cycles, from `rx` to `rx_s`.
- **Data sample points** fall 16 ticks apart, starting 16 ticks after start-bit confirmation, i.e. near mid-bit.
- **Output latency.** `data_valid`/`frame_err` assert in the `clk` cycle after the stop-sample tick and stay high for exactly one cycle. `data_out` updates in that same cycle.
- **End-of-frame timing.** IDLE is re-entered about half a bit before the nominal stop-bit end. A start bit immediately following is therefore detected with no lost frame.
- **`busy`** rises the cycle after the START transition and falls together with the `data_valid`/`frame_err` pulse.

## Test plan
- **Reset:** hold `rst_n`=0 with `rx` toggling → all outputs 0. Release with `rx`=1 → outputs stay 0 and `busy`=0.
- **Single byte:** `baud_tick` every 4 clks; send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1), 16 ticks per bit → exactly one `data_valid` pulse, `data_out`=0xA5, `frame_err` never high.
- **False start:** drive `rx` low for 3 ticks, then high → `busy` pulses, then returns to IDLE; no `data_valid` or `frame_err`; `data_out` unchanged.
- **Framing error:** after a good 0x3C, send 0xC3 with the stop bit low → one `frame_err` pulse, no `data_valid`, `data_out` stays 0x3C.
- **Back-to-back:** send 0x00, 0xFF, 0x55 with zero idle between frames → three `data_valid` pulses in order, values 0x00, 0xFF, 0x55, no errors.
- **Reset mid-frame:** assert `rst_n` low during bit 4 of 0x81, then resend 0x81 → no pulse for the aborted frame; second frame gives `data_out`=0x81.
